// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit with HI/LO result registers for a
// single-cycle datapath. multu (unsigned WIDTH x WIDTH -> 2*WIDTH) and
// div (signed WIDTH / WIDTH) each take WIDTH iteration cycles. While an
// operation is pending, stall freezes PC/fetch.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   cmul    in   [1:0] op: 0 none, 1 multu, 2 div, 3 reserved (treated as none)
//   op_a    in   [WIDTH-1:0] multiplicand / dividend
//   op_b    in   [WIDTH-1:0] multiplier / divisor
//   stall   out  combinational freeze request
//   busy    out  registered, high while iterating
//   done    out  registered, one-cycle pulse when the result is committed
//   hi      out  [WIDTH-1:0] upper product / remainder
//   lo      out  [WIDTH-1:0] lower product / quotient
//   div0    out  divide-by-zero pulse (only with MULDIV_DIVZERO_FLAG_EN)
//
// Build option
//   MULDIV_DIVZERO_FLAG_EN : adds div0; a div by zero leaves hi/lo untouched
//                            and pulses div0 with done. Without it, a div by
//                            zero writes lo = all-ones, hi = op_a.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cmul = multu/div; operands latched on issue
// RUN   | one shift-add / restoring shift-subtract step per cycle
// DONE  | result visible in hi/lo, done pulses, back to IDLE
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cmul,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand, or divisor magnitude
    logic [2*WIDTH-1:0]   work_q, work_d;     // {acc, multiplier} or {rem, quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic                 div0_q, div0_d;
`endif

    logic                 issue;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_mag, rem_mag;
    logic [WIDTH-1:0]     quo_s, rem_s;
    logic                 b_zero;

    assign issue = (cmul == 2'd1) || (cmul == 2'd2);

    always_comb begin
        // datapath step candidates
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};

        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ge};

        quo_mag   = div_next[WIDTH-1:0];
        rem_mag   = div_next[2*WIDTH-1:WIDTH];
        quo_s     = (a_neg_q ^ b_neg_q) ? -quo_mag : quo_mag;
        rem_s     = a_neg_q ? -rem_mag : rem_mag;
        b_zero    = (opnd_q == '0);

        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
        div0_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    is_div_d = (cmul == 2'd2);
                    if (cmul == 2'd2) begin
                        a_neg_d = op_a[WIDTH-1];
                        b_neg_d = op_b[WIDTH-1];
                        opnd_d  = op_b[WIDTH-1] ? -op_b : op_b;
                        work_d  = {{WIDTH{1'b0}}, (op_a[WIDTH-1] ? -op_a : op_a)};
                    end else begin
                        a_neg_d = 1'b0;
                        b_neg_d = 1'b0;
                        opnd_d  = op_b;
                        work_d  = {{WIDTH{1'b0}}, op_a};
                    end
                end
            end

            S_RUN: begin
                work_d  = is_div_q ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = mul_next[2*WIDTH-1:WIDTH];
                        lo_d = mul_next[WIDTH-1:0];
                    end else if (b_zero) begin
`ifdef MULDIV_DIVZERO_FLAG_EN
                        div0_d = 1'b1;
`else
                        // With a zero divisor every step "succeeds", so the
                        // remainder field ends up holding the dividend
                        // magnitude; re-signing it recovers the original op_a.
                        hi_d = rem_s;
                        lo_d = {WIDTH{1'b1}};
`endif
                    end else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opnd_q   <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div0_q   <= div0_d;
`endif
        end
    end

    // Low in DONE so the PC advances while the result is committed.
    assign stall = ((state_q == S_IDLE) && issue) || (state_q == S_RUN);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases plus randomized multu/div
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cmul = 2'd0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          stall, busy, done;
    logic [W-1:0]  hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic          div0;
`endif

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmul  (cmul),
        .op_a  (op_a),
        .op_b  (op_b),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        ,
        .div0  (div0)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural rules.
    task automatic model(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        if (k == 2'd1) begin
            p = {32'b0, a} * {32'b0, b};
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == '0) begin
`ifndef MULDIV_DIVZERO_FLAG_EN
            exp_lo = '1;
            exp_hi = a;
`endif
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    // Issue one op and follow it to DONE. cmul stays asserted through DONE,
    // as a held instruction would; the next call presents the following one.
    task automatic do_op(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        @(negedge clk);
        cmul = k; op_a = a; op_b = b;
        #1;
        chk("stall_issue", 64'(stall), 64'(1));
        chk("done_idle", 64'(done), 64'(0));
        cyc = 1;
        @(negedge clk);
        chk("busy_run", 64'(busy), 64'(1));
        while (stall && cyc < 100) begin
            cyc++;
            if (cyc == 6) begin
                chk("hi_hold", 64'(hi), 64'(exp_hi));
                chk("lo_hold", 64'(lo), 64'(exp_lo));
            end
            op_a = $urandom;
            op_b = $urandom;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(cyc), 64'(W + 1));
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("div0", 64'(div0), 64'((k == 2'd2) && (b == '0)));
`endif
        model(k, a, b);
        chk("hi", 64'(hi), 64'(exp_hi));
        chk("lo", 64'(lo), 64'(exp_lo));
    endtask

    task automatic idle_cycle(input logic [1:0] k);
        @(negedge clk);
        cmul = k; op_a = $urandom; op_b = $urandom;
        #1;
        chk("stall_none", 64'(stall), 64'(0));
        @(negedge clk);
        chk("busy_none", 64'(busy), 64'(0));
        chk("hi_none", 64'(hi), 64'(exp_hi));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom_range(0, 15));
            4:       return -W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // directed
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'd2, 32'd5, 32'd0);
        do_op(2'd2, 32'hFFFF_FFFB, 32'd0);
        do_op(2'd1, 32'd3, 32'd4);
        do_op(2'd2, 32'd100, 32'd7);
        idle_cycle(2'd3);
        idle_cycle(2'd0);

        // randomized, with occasional non-issuing cycles in between
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(1, 2)), pick(), pick());
            if ($urandom_range(0, 3) == 0)
                idle_cycle(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
        end

        // reset in the middle of RUN
        @(negedge clk);
        cmul = 2'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        repeat (11) @(negedge clk);
        chk("busy_pre_rst", 64'(busy), 64'(1));
        cmul = 2'd0;
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_stall", 64'(stall), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        cmul = 2'd3;
        #1;
        chk("rsvd_stall", 64'(stall), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(2'd3);
        do_op(2'd2, 32'hFFFF_FF9C, 32'd7);
        idle_cycle(2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
